lsu_wb_ctrl: RTL and testbench
==============================

Name: lsu_wb_ctrl

Overview:
Multi-cycle load/store unit that produces register-file writes, owned by the writer side of the register-file write port.
- Accepts one memory op at a time from the EX/MEM pipeline via a valid/ready handshake.
- Drives a request/grant/response data-memory interface.
- For loads: aligns and sign/zero-extends the returned word, then issues a single-cycle reg_wen/reg_waddr/reg_wdata write to the register file.
- Holds busy high to stall the pipeline while an op is in flight.

Parameters:
AW, 32, address width (byte address); data path fixed at 32 bits, 4 byte lanes
RW, 5, register address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline op valid
req_ready  out  1  unit can accept op
req_we  in  1  1=store, 0=load
req_size  in  2  00=none, 01=byte, 10=half, 11=word
req_sign_ext  in  1  load sign-extend (1) / zero-extend (0)
req_addr  in  AW  byte address
req_wdata  in  32  store data (low bits significant)
req_rd  in  RW  load destination register
dmem_req  out  1  memory request
dmem_we  out  1  memory write
dmem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte-lane write strobes
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data word
reg_wen  out  1  register write enable (1-cycle pulse)
reg_waddr  out  RW  register write address
reg_wdata  out  32  register write data
busy  out  1  op in flight (state != IDLE)
misalign  out  1  misaligned-access pulse

Behaviour:
- Reset values: clk is the clock; rst_n is the reset, asynchronous and active-low.
  - State = IDLE.
  - dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata = 0.
  - reg_wen = 0, reg_waddr = 0, reg_wdata = 0.
  - busy = 0, misalign = 0.
  - req_ready = 1, because req_ready = (state==IDLE).
- Reset mid-op: the op is abandoned, no write-back occurs, and any later dmem_rvalid/gnt for it is ignored.
- IDLE:
  - Accept when req_valid && req_ready; latch we, size, sign_ext, addr, wdata, rd.
  - size==00 is accepted and dropped; stay IDLE.
  - Otherwise go to REQ.
- REQ:
  - dmem_req=1; dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are stable until dmem_gnt.
  - On gnt, a store goes to IDLE with no write-back; a load goes to RESP.
- RESP: wait for dmem_rvalid; register the extracted data and go to WB.
- WB:
  - reg_wen=1 for exactly one cycle, with reg_waddr=rd and reg_wdata=extracted data.
  - If rd==0, reg_wen stays 0.
  - Then go to IDLE.
- Outputs are registered from state and latched fields; there are no combinational paths from dmem inputs to reg_* outputs.
- Store lanes:
  - byte: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: wstrb = 4'b0011 << (2*addr[1]); wdata = {2{wdata[15:0]}}.
  - word: wstrb = 4'b1111; wdata = wdata.
- Load extraction:
  - byte lane selected by addr[1:0]; half selected by addr[1]; word taken whole.
  - Extend to 32 bits with sign or zero according to sign_ext.
- Minimum load latency: accept at cycle 0, dmem_req in cycle 1 (gnt same cycle), rvalid in cycle 2, reg_wen in cycle 3.
- Minimum store latency: accept cycle 0, gnt cycle 1, ready again cycle 2.
- dmem_gnt outside REQ and dmem_rvalid outside RESP are ignored.
- busy is asserted from the cycle after acceptance through WB inclusive.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Misaligned ops (half with addr[0]=1, word with addr[1:0]!=0) issue no dmem_req and no write-back.
  - misalign pulses 1 cycle in the cycle after acceptance; the unit then returns to IDLE.
- Undefined:
  - misalign is tied 0.
  - Misaligned ops are performed at the aligned-down lane: half uses addr[1] only, word ignores addr[1:0].

Test Plan:
- Hold rst_n=0 -> all outputs at reset values, req_ready=1; release rst_n -> still IDLE, busy=0.
- Load byte, addr=0x103, rd=5, dmem_rdata=0x80FF1234:
  - sign_ext=1 -> dmem_addr=0x100, reg_wen pulse with reg_waddr=5, reg_wdata=0xFFFFFF80.
  - sign_ext=0 -> reg_wdata=0x00000080.
- Store half, addr=0x202, wdata=0x0000ABCD -> dmem_we=1, dmem_addr=0x200, dmem_wstrb=4'b1100, dmem_wdata=0xABCDABCD, no reg_wen.
- Load word, addr=0x40, rd=7, gnt delayed 3 cycles, rvalid 2 cycles after gnt, rdata=0xDEADBEEF:
  - dmem_req held with stable addr until gnt; busy high throughout.
  - Exactly one reg_wen with reg_wdata=0xDEADBEEF.
  - Repeat with rd=0 -> no reg_wen.
- Load word, addr=0x101:
  - With MISALIGN_TRAP_EN -> one misalign pulse, no dmem_req, no reg_wen.
  - Without MISALIGN_TRAP_EN -> dmem_addr=0x100, normal write-back.
- Load accepted, rst_n pulsed low while in RESP, then dmem_rvalid=1 -> state IDLE, reg_wen never asserted, req_ready=1.

Source files
------------

// File: rtl/lsu_wb_ctrl.sv
// Multi-cycle load/store unit: one op at a time over a req/gnt/rvalid data port,
// load results written back to the register file. Optional trap build: MISALIGN_TRAP_EN.
module lsu_wb_ctrl #(
  parameter int unsigned AW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_sign_ext,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [RW-1:0] req_rd,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  output logic [3:0]    dmem_wstrb,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [31:0]   dmem_rdata,
  output logic          reg_wen,
  output logic [RW-1:0] reg_waddr,
  output logic [31:0]   reg_wdata,
  output logic          busy,
  output logic          misalign
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_RESP, ST_WB, ST_MIS} state_t;

  state_t        state;
  logic          op_we;
  logic [1:0]    op_size;
  logic          op_sext;
  logic [1:0]    op_off;
  logic [RW-1:0] op_rd;

  logic          mis_c;
  logic [3:0]    wstrb_c;
  logic [DW-1:0] wdata_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [DW-1:0] ext_c;

`ifdef MISALIGN_TRAP_EN
  assign mis_c = ((req_size == 2'b10) && req_addr[0]) ||
                 ((req_size == 2'b11) && (req_addr[1:0] != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  // Store lane placement from the incoming request
  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = req_wdata;
    case (req_size)
      2'b01: begin
        wstrb_c = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b10: begin
        wstrb_c = 4'b0011 << {req_addr[1], 1'b0};
        wdata_c = {2{req_wdata[15:0]}};
      end
      2'b11:   wstrb_c = 4'b1111;
      default: wstrb_c = 4'b0000;
    endcase
  end

  // Load lane extraction and extension from the latched op
  always_comb begin
    byte_c = dmem_rdata[{op_off, 3'b000} +: 8];
    half_c = op_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ext_c  = dmem_rdata;
    case (op_size)
      2'b01:   ext_c = op_sext ? {{24{byte_c[7]}}, byte_c} : {24'h0, byte_c};
      2'b10:   ext_c = op_sext ? {{16{half_c[15]}}, half_c} : {16'h0, half_c};
      default: ext_c = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_we      <= 1'b0;
      op_size    <= 2'b00;
      op_sext    <= 1'b0;
      op_off     <= 2'b00;
      op_rd      <= '0;
      req_ready  <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= 4'b0000;
      reg_wen    <= 1'b0;
      reg_waddr  <= '0;
      reg_wdata  <= '0;
      busy       <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_we   <= req_we;
            op_size <= req_size;
            op_sext <= req_sign_ext;
            op_off  <= req_addr[1:0];
            op_rd   <= req_rd;
            if (req_size == 2'b00) begin
              state <= ST_IDLE;
            end else if (mis_c) begin
              state     <= ST_MIS;
              misalign  <= 1'b1;
              busy      <= 1'b1;
              req_ready <= 1'b0;
            end else begin
              state      <= ST_REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= req_we;
              dmem_addr  <= {req_addr[AW-1:2], 2'b00};
              dmem_wdata <= wdata_c;
              dmem_wstrb <= req_we ? wstrb_c : 4'b0000;
              busy       <= 1'b1;
              req_ready  <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'b0000;
            if (op_we) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (dmem_rvalid) begin
            state     <= ST_WB;
            reg_wen   <= (op_rd != '0);
            reg_waddr <= op_rd;
            reg_wdata <= ext_c;
          end
        end
        ST_WB: begin
          state     <= ST_IDLE;
          reg_wen   <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        ST_MIS: begin
          state     <= ST_IDLE;
          misalign  <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          dmem_req  <= 1'b0;
          dmem_we   <= 1'b0;
          reg_wen   <= 1'b0;
          misalign  <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb_ctrl.sv
// Self-checking bench for lsu_wb_ctrl; write-backs are checked against a scoreboard queue.
module tb_lsu_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_sign_ext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        reg_wen, busy, misalign;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;

  lsu_wb_ctrl #(.AW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_sign_ext(req_sign_ext), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .busy(busy), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  wb_t exp_q[$];
  int  vectors = 0;
  int  errors  = 0;
  int  cyc     = 0;
  int  wen_count = 0;
  int  wen_cyc   = 0;

  // Observations from the last run_op
  int          acc_cyc, ready_cyc, o_mis;
  logic        o_req, o_we, o_stable, o_busy_bad, o_timeout, o_acc_ready;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_wstrb;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write-back pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && reg_wen) begin
      wb_t e;
      wen_count++;
      wen_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wen got waddr=%0d wdata=%h, required no write", reg_waddr, reg_wdata);
      end else begin
        e = exp_q.pop_front();
        if (reg_waddr !== e.waddr || reg_wdata !== e.wdata) begin
          errors++;
          $display("FAIL wb_data got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                   reg_waddr, reg_wdata, e.waddr, e.wdata);
        end
      end
    end
  end

  function automatic logic [31:0] exp_load(logic [1:0] size, logic sext, logic [1:0] off, logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*int'(off) +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    if (size == 2'b01) return sext ? {{24{b[7]}}, b} : {24'h0, b};
    if (size == 2'b10) return sext ? {{16{h[15]}}, h} : {16'h0, h};
    return d;
  endfunction

  function automatic logic [3:0] exp_strb(logic [1:0] size, logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    if (size == 2'b01) s[off] = 1'b1;
    else if (size == 2'b10) s = off[1] ? 4'b1100 : 4'b0011;
    else if (size == 2'b11) s = 4'b1111;
    return s;
  endfunction

  // Issue one op and play the memory side with the given grant/response delays
  task automatic run_op(input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    int n;
    o_acc_ready = req_ready;
    acc_cyc = cyc;
    req_valid = 1'b1; req_we = we; req_size = size; req_sign_ext = sext;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
    o_req = 1'b0; o_stable = 1'b1; o_busy_bad = 1'b0; o_mis = 0; o_timeout = 1'b0;
    n = 0;
    while (!dmem_req && !req_ready && n < 10) begin
      if (misalign) o_mis++;
      if (busy !== 1'b1) o_busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (misalign) o_mis++;
    if (n >= 10) o_timeout = 1'b1;
    if (dmem_req) begin
      o_req = 1'b1; o_addr = dmem_addr; o_we = dmem_we; o_wstrb = dmem_wstrb; o_wdata = dmem_wdata;
      for (int i = 0; i < gnt_dly; i++) begin
        @(negedge clk);
        if (dmem_req !== 1'b1 || dmem_addr !== o_addr || dmem_we !== o_we ||
            dmem_wstrb !== o_wstrb || dmem_wdata !== o_wdata) o_stable = 1'b0;
        if (busy !== 1'b1) o_busy_bad = 1'b1;
      end
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      if (!we) begin
        for (int i = 0; i < rv_dly; i++) begin
          if (busy !== 1'b1) o_busy_bad = 1'b1;
          @(negedge clk);
        end
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      end
      n = 0;
      while (!req_ready && n < 10) begin
        if (busy !== 1'b1) o_busy_bad = 1'b1;
        @(negedge clk);
        n++;
      end
      if (!req_ready) o_timeout = 1'b1;
    end
    ready_cyc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign_ext = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, reg_wen, reg_waddr, reg_wdata, busy, misalign} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b we=%b strb=%b addr=%h wdata=%h wen=%b waddr=%0d rwdata=%h busy=%b mis=%b, required all 0",
               dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, reg_wen, reg_waddr, reg_wdata, busy, misalign);
    end
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", req_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle got busy=%b ready=%b required busy=0 ready=1", busy, req_ready);
    end
  endtask

  task automatic test_load_byte();
    for (int s = 1; s >= 0; s--) begin
      int wc;
      wc = wen_count;
      exp_q.push_back('{5'd5, (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080});
      run_op(1'b0, 2'b01, 1'(s), 32'h103, 32'h0, 5'd5, 0, 0, 32'h80FF_1234);
      vectors++;
      if (o_req !== 1'b1 || o_addr !== 32'h100 || o_we !== 1'b0 || o_acc_ready !== 1'b1) begin
        errors++; $display("FAIL ldb_req sext=%0d got req=%b addr=%h we=%b ready=%b required 1/00000100/0/1", s, o_req, o_addr, o_we, o_acc_ready);
      end
      vectors++;
      if (wen_count - wc !== 1 || wen_cyc - acc_cyc !== 3) begin
        errors++; $display("FAIL ldb_wen sext=%0d got count=%0d latency=%0d required 1 and 3", s, wen_count - wc, wen_cyc - acc_cyc);
      end
      vectors++;
      if (o_busy_bad !== 1'b0 || o_timeout !== 1'b0) begin
        errors++; $display("FAIL ldb_busy got busy_bad=%b timeout=%b required 0/0", o_busy_bad, o_timeout);
      end
    end
  endtask

  task automatic test_store();
    int wc;
    wc = wen_count;
    run_op(1'b1, 2'b10, 1'b0, 32'h202, 32'h0000_ABCD, 5'd9, 0, 0, 32'h0);
    vectors++;
    if (o_we !== 1'b1 || o_addr !== 32'h200 || o_wstrb !== 4'b1100 || o_wdata !== 32'hABCD_ABCD) begin
      errors++; $display("FAIL sth_bus got we=%b addr=%h strb=%b wdata=%h required 1/00000200/1100/abcdabcd", o_we, o_addr, o_wstrb, o_wdata);
    end
    vectors++;
    if (wen_count !== wc || ready_cyc - acc_cyc !== 2) begin
      errors++; $display("FAIL sth_timing got wen=%0d ready_lat=%0d required 0 and 2", wen_count - wc, ready_cyc - acc_cyc);
    end
    run_op(1'b1, 2'b01, 1'b0, 32'h201, 32'h1234_565A, 5'd9, 1, 0, 32'h0);
    vectors++;
    if (o_wstrb !== 4'b0010 || o_wdata !== 32'h5A5A_5A5A || o_addr !== 32'h200 || o_stable !== 1'b1) begin
      errors++; $display("FAIL stb_bus got strb=%b wdata=%h addr=%h stable=%b required 0010/5a5a5a5a/00000200/1", o_wstrb, o_wdata, o_addr, o_stable);
    end
  endtask

  task automatic test_delayed_load();
    int wc;
    wc = wen_count;
    exp_q.push_back('{5'd7, 32'hDEAD_BEEF});
    run_op(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 5'd7, 3, 2, 32'hDEAD_BEEF);
    vectors++;
    if (o_addr !== 32'h40 || o_stable !== 1'b1 || o_busy_bad !== 1'b0 || o_timeout !== 1'b0) begin
      errors++; $display("FAIL ldw_hold got addr=%h stable=%b busy_bad=%b timeout=%b required 00000040/1/0/0", o_addr, o_stable, o_busy_bad, o_timeout);
    end
    vectors++;
    if (wen_count - wc !== 1) begin errors++; $display("FAIL ldw_wen_count got %0d required 1", wen_count - wc); end
    wc = wen_count;
    run_op(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 5'd0, 3, 2, 32'hDEAD_BEEF);
    vectors++;
    if (wen_count !== wc || o_req !== 1'b1) begin
      errors++; $display("FAIL ldw_rd0 got wen=%0d req=%b required 0 and 1", wen_count - wc, o_req);
    end
  endtask

  task automatic test_misalign();
    int wc;
    wc = wen_count;
`ifdef MISALIGN_TRAP_EN
    run_op(1'b0, 2'b11, 1'b0, 32'h101, 32'h0, 5'd4, 0, 0, 32'h1234_5678);
    repeat (2) @(negedge clk);
    vectors++;
    if (o_mis !== 1 || o_req !== 1'b0 || wen_count !== wc || req_ready !== 1'b1) begin
      errors++; $display("FAIL mis_trap got pulses=%0d req=%b wen=%0d ready=%b required 1/0/0/1", o_mis, o_req, wen_count - wc, req_ready);
    end
`else
    exp_q.push_back('{5'd4, 32'h1234_5678});
    run_op(1'b0, 2'b11, 1'b0, 32'h101, 32'h0, 5'd4, 0, 0, 32'h1234_5678);
    vectors++;
    if (o_addr !== 32'h100 || wen_count - wc !== 1 || o_mis !== 0) begin
      errors++; $display("FAIL mis_aligned_down got addr=%h wen=%0d pulses=%0d required 00000100/1/0", o_addr, wen_count - wc, o_mis);
    end
    exp_q.push_back('{5'd3, 32'hFFFF_8899});
    run_op(1'b0, 2'b10, 1'b1, 32'h203, 32'h0, 5'd3, 0, 1, 32'h8899_1122);
`endif
  endtask

  task automatic test_size_none();
    int wc;
    wc = wen_count;
    run_op(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 5'd2, 0, 0, 32'h0);
    vectors++;
    if (o_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || wen_count !== wc) begin
      errors++; $display("FAIL size_none got req=%b busy=%b ready=%b wen=%0d required 0/0/1/0", o_req, busy, req_ready, wen_count - wc);
    end
  endtask

  task automatic test_ignore_idle();
    int wc;
    logic bad;
    wc = wen_count;
    bad = 1'b0;
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    repeat (2) begin
      @(negedge clk);
      if (dmem_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bad !== 1'b0 || wen_count !== wc) begin
      errors++; $display("FAIL idle_ignore got disturbed=%b wen=%0d required 0 and 0", bad, wen_count - wc);
    end
  endtask

  task automatic test_reset_mid_op();
    int wc;
    wc = wen_count;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_addr = 32'h80; req_rd = 5'd6;
    @(negedge clk);
    req_valid = 1'b0;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    vectors++;
    if (busy !== 1'b1 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL mid_in_resp got busy=%b req=%b required 1 and 0", busy, dmem_req);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (wen_count !== wc || reg_wen !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got wen=%0d reg_wen=%b busy=%b ready=%b required 0/0/0/1", wen_count - wc, reg_wen, busy, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic        we, sext;
      logic [1:0]  size, off;
      logic [4:0]  rd;
      logic [31:0] addr, wd, rdat;
      int          wc;
      we   = 1'($urandom_range(0, 1));
      sext = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(1, 3));
      off  = (size == 2'b01) ? 2'($urandom_range(0, 3)) : (size == 2'b10) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | {30'h0, off};
      rd   = 5'($urandom_range(0, 31));
      wd   = $urandom;
      rdat = $urandom;
      wc   = wen_count;
      if (!we && rd != 5'd0) exp_q.push_back('{rd, exp_load(size, sext, off, rdat)});
      run_op(we, size, sext, addr, wd, rd, $urandom_range(0, 2), $urandom_range(0, 2), rdat);
      vectors++;
      if (o_addr !== {addr[31:2], 2'b00} || o_we !== we || o_timeout !== 1'b0 ||
          (we && o_wstrb !== exp_strb(size, off)) ||
          (!we && wen_count - wc !== ((rd != 5'd0) ? 1 : 0))) begin
        errors++; $display("FAIL rand_op%0d got addr=%h we=%b strb=%b wen=%0d timeout=%b required addr=%h we=%b strb=%b",
                           i, o_addr, o_we, o_wstrb, wen_count - wc, o_timeout, {addr[31:2], 2'b00}, we, exp_strb(size, off));
      end
      if (we && size == 2'b11) begin
        vectors++;
        if (o_wdata !== wd) begin errors++; $display("FAIL rand_wdata%0d got %h required %h", i, o_wdata, wd); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_byte();
    test_store();
    test_delayed_load();
    test_misalign();
    test_size_none();
    test_ignore_idle();
    test_reset_mid_op();
    test_back_to_back();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending writes, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
